fetch_stall_ctrl: RTL and testbench
===================================

# fetch_stall_ctrl

Fetch-side consumer of the pipeline's load-use stall and branch-flush controls. It owns the PC register and the IF/ID pipeline register. It applies the hazard unit's `pc_write`, `ifid_write` and `ctrl_hazard` outputs and the EX-stage branch redirect. It also keeps saturating stall and flush counters for performance analysis. It sits between instruction memory and the decode stage of the 5-stage RISC-V pipeline.

## Interface
Clock is single; reset is synchronous and active-high (`clk`, `rst`).

Parameters:
- `XLEN`, 32, PC and address width
- `RESET_PC`, 0, PC value loaded on reset
- `CNT_W`, 32, width of the performance counters

Ports:
- `clk`  in  1  pipeline clock
- `rst`  in  1  synchronous active-high reset
- `pc_write`  in  1  from hazard unit; 0 holds the PC
- `ifid_write`  in  1  from hazard unit; 0 holds IF/ID
- `ctrl_hazard`  in  1  from hazard unit; 1 requests a bubble into ID/EX
- `branch_taken`  in  1  EX-stage redirect request
- `branch_target`  in  XLEN  redirect address
- `imem_addr`  out  XLEN  instruction fetch address
- `imem_rdata`  in  32  instruction word, combinational read of `imem_addr`
- `ifid_pc`  out  XLEN  registered PC of the decode-stage instruction
- `ifid_instr`  out  32  registered decode-stage instruction
- `ifid_valid`  out  1  decode-stage instruction is real (not flushed/reset)
- `idex_bubble`  out  1  zero the ID/EX control bits this cycle
- `hz_mismatch`  out  1  sticky: `pc_write` and `ifid_write` disagreed
- `stall_cnt`  out  CNT_W  load-use stall cycles, saturating
- `flush_cnt`  out  CNT_W  branch redirects, saturating

## Operation
- `imem_addr` = `pc`, combinational.
- PC next-state, in priority order:
  - `rst`: `pc` ← `RESET_PC`.
  - `branch_taken`: `pc` ← `branch_target`.
  - `pc_write`: `pc` ← `pc + 4`, modulo 2^XLEN; 0xFFFFFFFC wraps to 0.
  - Otherwise: `pc` holds.
- IF/ID next-state, in priority order:
  - `rst`: `ifid_pc` ← 0, `ifid_instr` ← 0x00000013 (NOP), `ifid_valid` ← 0.
  - `branch_taken`: flush; same values as reset.
  - `ifid_write`: `ifid_pc` ← `pc`, `ifid_instr` ← `imem_rdata`, `ifid_valid` ← 1.
  - Otherwise: all three hold.
- `idex_bubble` = `ctrl_hazard | branch_taken`, combinational. It is 0 while `rst` is high.
- `hz_mismatch` is set in any cycle where `!rst && !branch_taken && (pc_write != ifid_write)`. It stays set until reset.
- `stall_cnt` increments on `ctrl_hazard && !branch_taken` and saturates at 2^CNT_W−1.
- `flush_cnt` increments on `branch_taken` and saturates likewise.
- Both counters reset to 0.
- `branch_taken` overrides a simultaneous stall. The stalled instruction is on the wrong path, so it is discarded and the cycle is not counted as a stall.
- Write enables are independent. If the hazard unit desynchronises them, the block still obeys each enable as given and flags `hz_mismatch`.

## Timing
- Reset values: `pc` = `RESET_PC`, `imem_addr` = `RESET_PC`, `ifid_pc` = 0, `ifid_instr` = 0x00000013, `ifid_valid` = 0, `hz_mismatch` = 0, `stall_cnt` = 0, `flush_cnt` = 0, `idex_bubble` = 0.
- First cycle after `rst` falls: fetch from `RESET_PC`. That instruction is in IF/ID, with `ifid_valid` = 1, one cycle later.
- Fetch-to-decode latency is 1 cycle.
- A stall in cycle N holds `pc` and IF/ID through edge N+1. Fetch resumes when the enables return to 1.
- Redirect in cycle N:
  - N+1: `pc` = target, `ifid_valid` = 0.
  - N+2: target instruction is in IF/ID, valid.
- `rst` asserted mid-stall or mid-redirect wins at the same edge. No state survives.
- Consecutive stalls of any length are legal. Nothing advances and `stall_cnt` counts every cycle.

## Test plan
- Reset, `RESET_PC`=0x100, all enables 1, memory returns addr-tagged words → `imem_addr` goes 0x100, 0x104, 0x108; `ifid_pc`/`ifid_instr` follow one cycle later; `ifid_valid` is 0 for the first cycle only.
- Hold `pc_write`=`ifid_write`=0 and `ctrl_hazard`=1 for 2 cycles at `pc`=0x104 → `pc` and IF/ID frozen for 2 edges, `idex_bubble`=1 for 2 cycles, `stall_cnt`=2, then resume at 0x108.
- `branch_taken`=1 with target 0x200 in the same cycle as `ctrl_hazard`=1 and both enables 0 → next `pc`=0x200, `ifid_valid`=0, `ifid_instr`=0x00000013, `flush_cnt`+1, `stall_cnt` unchanged.
- `pc` at 0xFFFFFFFC, `pc_write`=1 → next `pc`=0x00000000.
- `pc_write`=1 with `ifid_write`=0 for one cycle → `pc` advances, IF/ID holds, `hz_mismatch` rises and stays 1 until `rst`.
- `CNT_W`=2: 5 stall cycles → `stall_cnt` reads 1, 2, 3, 3, 3. Then assert `rst` mid-stall → all outputs at their reset values on the next edge.

Source files
------------

// File: rtl/fetch_stall_ctrl.sv
// Purpose : fetch-side PC and IF/ID register owner; applies hazard-unit stalls, EX branch flushes, saturating perf counters.
// Latency : fetch-to-decode 1 cycle; a redirect puts the target in IF/ID 2 cycles after branch_taken.
// Backpressure: pc_write / ifid_write = 0 hold PC / IF/ID independently; branch_taken overrides any stall.
//
// Ports:
//   clk, rst                       pipeline clock, synchronous active-high reset
//   pc_write, ifid_write           hazard-unit write enables (0 = hold)
//   ctrl_hazard                    hazard-unit bubble request for ID/EX
//   branch_taken, branch_target    EX-stage redirect
//   imem_addr / imem_rdata         combinational instruction memory port
//   ifid_pc, ifid_instr, ifid_valid  decode-stage register
//   idex_bubble                    zero ID/EX control this cycle
//   hz_mismatch                    sticky flag: write enables disagreed
//   stall_cnt, flush_cnt           saturating performance counters
module fetch_stall_ctrl #(
  parameter int unsigned            XLEN     = 32,
  parameter logic [XLEN-1:0]        RESET_PC = '0,
  parameter int unsigned            CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_write,
  input  logic             ifid_write,
  input  logic             ctrl_hazard,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_target,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [XLEN-1:0]  ifid_pc,
  output logic [31:0]      ifid_instr,
  output logic             ifid_valid,
  output logic             idex_bubble,
  output logic             hz_mismatch,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  ifid_pc_q, ifid_pc_d;
  logic [31:0]      ifid_instr_q, ifid_instr_d;
  logic             ifid_valid_q, ifid_valid_d;
  logic             hz_mismatch_q, hz_mismatch_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // PC next state: redirect beats the stall enable. Addition wraps naturally.
  always_comb begin
    pc_d = pc_q;
    if (branch_taken) begin
      pc_d = branch_target;
    end else if (pc_write) begin
      pc_d = pc_q + XLEN'(4);
    end
  end

  // IF/ID next state: a redirect discards the (wrong-path) fetched word.
  always_comb begin
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    if (branch_taken) begin
      ifid_pc_d    = '0;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end else if (ifid_write) begin
      ifid_pc_d    = pc_q;
      ifid_instr_d = imem_rdata;
      ifid_valid_d = 1'b1;
    end
  end

  // Sticky enable-disagreement flag and saturating counters. A stall cycle
  // that coincides with a redirect is not a stall: that instruction is dead.
  always_comb begin
    hz_mismatch_d = hz_mismatch_q;
    if (!branch_taken && (pc_write != ifid_write)) begin
      hz_mismatch_d = 1'b1;
    end

    stall_cnt_d = stall_cnt_q;
    if (ctrl_hazard && !branch_taken && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    flush_cnt_d = flush_cnt_q;
    if (branch_taken && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      ifid_pc_q     <= '0;
      ifid_instr_q  <= NOP_INSTR;
      ifid_valid_q  <= 1'b0;
      hz_mismatch_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      pc_q          <= pc_d;
      ifid_pc_q     <= ifid_pc_d;
      ifid_instr_q  <= ifid_instr_d;
      ifid_valid_q  <= ifid_valid_d;
      hz_mismatch_q <= hz_mismatch_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  // Bubble is suppressed during reset so ID/EX sees clean control.
  assign idex_bubble = !rst && (ctrl_hazard || branch_taken);
  assign ifid_pc     = ifid_pc_q;
  assign ifid_instr  = ifid_instr_q;
  assign ifid_valid  = ifid_valid_q;
  assign hz_mismatch = hz_mismatch_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Purpose : bench for fetch_stall_ctrl; two instances (32-bit and 2-bit counters) share stimulus.
// Latency : checks comb outputs before each edge and registered state 1 time unit after it.
// Backpressure: stimulus drives stalls, desynchronised enables, redirects and resets.
module tb_fetch_stall_ctrl;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, pc_write, ifid_write, ctrl_hazard, branch_taken;
  logic [31:0] branch_target;

  logic [31:0] a_addr, a_rdata, a_ifpc, a_ifinstr;
  logic        a_ifvalid, a_bubble, a_mis;
  logic [31:0] a_stall, a_flush;

  logic [31:0] b_addr, b_rdata, b_ifpc, b_ifinstr;
  logic        b_ifvalid, b_bubble, b_mis;
  logic [1:0]  b_stall, b_flush;

  int checks = 0;
  int errors = 0;

  // Reference state, kept as plain values; counters are unbounded event counts.
  logic [31:0] m_pc, m_ifpc, m_ifinstr;
  logic        m_ifvalid, m_mis;
  longint      m_stall, m_flush;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hA500_0000;
  endfunction

  assign a_rdata = mem(a_addr);
  assign b_rdata = mem(b_addr);

  fetch_stall_ctrl #(.XLEN(32), .RESET_PC(RPC), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .pc_write(pc_write), .ifid_write(ifid_write),
    .ctrl_hazard(ctrl_hazard), .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(a_addr), .imem_rdata(a_rdata), .ifid_pc(a_ifpc), .ifid_instr(a_ifinstr),
    .ifid_valid(a_ifvalid), .idex_bubble(a_bubble), .hz_mismatch(a_mis),
    .stall_cnt(a_stall), .flush_cnt(a_flush));

  fetch_stall_ctrl #(.XLEN(32), .RESET_PC(RPC), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .pc_write(pc_write), .ifid_write(ifid_write),
    .ctrl_hazard(ctrl_hazard), .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(b_addr), .imem_rdata(b_rdata), .ifid_pc(b_ifpc), .ifid_instr(b_ifinstr),
    .ifid_valid(b_ifvalid), .idex_bubble(b_bubble), .hz_mismatch(b_mis),
    .stall_cnt(b_stall), .flush_cnt(b_flush));

  function automatic logic [63:0] sat(input longint c, input int w);
    longint mx;
    mx = (longint'(1) <<< w) - 1;
    return (c > mx) ? 64'(mx) : 64'(c);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc      = RPC;
    m_ifpc    = '0;
    m_ifinstr = NOP;
    m_ifvalid = 1'b0;
    m_mis     = 1'b0;
    m_stall   = 0;
    m_flush   = 0;
  endtask

  // Apply one clock edge of the specification's rules to the reference state.
  task automatic model_edge();
    logic [31:0] fetched;
    if (rst) begin
      model_reset();
      return;
    end
    fetched = mem(m_pc);
    if (branch_taken) begin
      m_ifpc = '0; m_ifinstr = NOP; m_ifvalid = 1'b0;
    end else if (ifid_write) begin
      m_ifpc = m_pc; m_ifinstr = fetched; m_ifvalid = 1'b1;
    end
    if (branch_taken)      m_pc = branch_target;
    else if (pc_write)     m_pc = m_pc + 32'd4;
    if (!branch_taken && (pc_write != ifid_write)) m_mis = 1'b1;
    if (ctrl_hazard && !branch_taken) m_stall++;
    if (branch_taken) m_flush++;
  endtask

  task automatic check_state();
    chk("a_pc",     64'(a_addr),    64'(m_pc));
    chk("a_ifpc",   64'(a_ifpc),    64'(m_ifpc));
    chk("a_instr",  64'(a_ifinstr), 64'(m_ifinstr));
    chk("a_valid",  64'(a_ifvalid), 64'(m_ifvalid));
    chk("a_mis",    64'(a_mis),     64'(m_mis));
    chk("a_stall",  64'(a_stall),   sat(m_stall, 32));
    chk("a_flush",  64'(a_flush),   sat(m_flush, 32));
    chk("b_pc",     64'(b_addr),    64'(m_pc));
    chk("b_valid",  64'(b_ifvalid), 64'(m_ifvalid));
    chk("b_stall",  64'(b_stall),   sat(m_stall, 2));
    chk("b_flush",  64'(b_flush),   sat(m_flush, 2));
  endtask

  // One cycle: drive, check combinational outputs, clock, check registered state.
  task automatic step(input logic r, input logic pw, input logic iw, input logic ch,
                      input logic bt, input logic [31:0] tg);
    logic exp_bub;
    rst = r; pc_write = pw; ifid_write = iw; ctrl_hazard = ch;
    branch_taken = bt; branch_target = tg;
    #1;
    exp_bub = r ? 1'b0 : (ch | bt);
    chk("a_bubble", 64'(a_bubble), 64'(exp_bub));
    chk("b_bubble", 64'(b_bubble), 64'(exp_bub));
    chk("a_addr",   64'(a_addr),   64'(m_pc));
    @(posedge clk);
    model_edge();
    #1;
    check_state();
  endtask

  initial begin
    logic [1:0] sat_seq [5];
    logic pw, iw, ch, bt, r;
    sat_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    rst = 1'b1; pc_write = 1'b1; ifid_write = 1'b1; ctrl_hazard = 1'b0;
    branch_taken = 1'b0; branch_target = '0;
    model_reset();
    @(posedge clk); #1;

    // Reset values, with hazard inputs active to show they are ignored.
    step(1, 0, 1, 1, 1, 32'h0000_0400);
    chk("rst_pc",    64'(a_addr),    64'(RPC));
    chk("rst_instr", 64'(a_ifinstr), 64'(NOP));

    // Sequential fetch from RESET_PC.
    step(0, 1, 1, 0, 0, '0);
    chk("seq_pc1",  64'(a_addr), 64'h104);
    chk("seq_ifpc", 64'(a_ifpc), 64'h100);
    // Two-cycle load-use stall at pc=0x104.
    step(0, 0, 0, 1, 0, '0);
    step(0, 0, 0, 1, 0, '0);
    chk("stall_hold_pc", 64'(a_addr), 64'h104);
    chk("stall_cnt2",    64'(a_stall), 64'd2);
    step(0, 1, 1, 0, 0, '0);
    chk("resume_pc", 64'(a_addr), 64'h108);
    step(0, 1, 1, 0, 0, '0);

    // Redirect coinciding with a stall.
    step(0, 0, 0, 1, 1, 32'h0000_0200);
    chk("redir_pc",    64'(a_addr),  64'h200);
    chk("redir_stall", 64'(a_stall), 64'd2);
    chk("redir_flush", 64'(a_flush), 64'd1);
    step(0, 1, 1, 0, 0, '0);
    chk("redir_ifpc", 64'(a_ifpc), 64'h200);

    // PC wrap at the top of the address space.
    step(0, 1, 1, 0, 1, 32'hFFFF_FFFC);
    step(0, 1, 1, 0, 0, '0);
    chk("wrap_pc", 64'(a_addr), 64'h0);

    // Desynchronised enables raise a sticky flag.
    step(0, 1, 0, 0, 0, '0);
    chk("mis_set", 64'(a_mis), 64'd1);
    step(0, 1, 1, 0, 0, '0);
    step(0, 1, 1, 0, 1, 32'h40);
    chk("mis_sticky", 64'(a_mis), 64'd1);

    // 2-bit counter saturation, then reset mid-stall.
    step(1, 1, 1, 0, 0, '0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1, 0, '0);
      chk("sat_seq", 64'(b_stall), 64'(sat_seq[i]));
    end
    step(1, 0, 0, 1, 0, '0);
    chk("rst_mid_stall", 64'(b_stall), 64'd0);
    chk("rst_mid_valid", 64'(a_ifvalid), 64'd0);
    step(0, 1, 1, 0, 0, '0);

    // Randomized phase against the reference model.
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 59) == 0);
      ch = ($urandom_range(0, 3) == 0);
      pw = !ch;
      iw = !ch;
      if ($urandom_range(0, 15) == 0) iw = !pw;
      bt = ($urandom_range(0, 7) == 0);
      step(r, pw, iw, ch, bt, $urandom & 32'hFFFF_FFFC);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
